reg_share_arbiter: RTL
======================

REG_SHARE_ARBITER -- requirements
Module: reg_share_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters (2..8).
REQ-002 Parameter WIDTH, default 8: width of the shared register.
REQ-003 Parameter HOLD, default 2: grant duration in cycles (1..15).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 req  input  NREQ  per-requester access request, level-sensitive.
REQ-007 wr_data  input  NREQ*WIDTH  requester i data at bits [i*WIDTH +: WIDTH].
REQ-008 gnt  output  NREQ  one-hot grant, registered.
REQ-009 q  output  WIDTH  shared register contents, registered.
REQ-010 qb  output  WIDTH  bitwise complement of q, always equal to ~q.
REQ-011 busy  output  1  high while in state HOLD, registered.

Function
REQ-012 The FSM SHALL have exactly two states: IDLE and HOLD.
REQ-013 IDLE with req==0: no change to any output or the pointer.
REQ-014 IDLE with req!=0: winner is the first asserted index after ptr, searching ptr+1 upward modulo NREQ.
REQ-015 On the same edge: gnt<=onehot(winner), q<=wr_data[winner], ptr<=winner, cnt<=HOLD-1, busy<=1, state<=HOLD.
REQ-016 HOLD with req[ptr]==1 and cnt!=0: cnt decrements; gnt and q are unchanged.
REQ-017 HOLD with req[ptr]==1 and cnt==0: gnt<=0, busy<=0, state<=IDLE.
- Result: gnt stays high for exactly HOLD cycles.
REQ-018 HOLD with req[ptr]==0: early release on that edge (gnt<=0, busy<=0, state<=IDLE); q is retained.
REQ-019 After each grant, at least one IDLE cycle with gnt==0 SHALL occur before the next grant.
REQ-020 Changes to wr_data or to other req bits during HOLD SHALL have no effect; q loads only on grant.
REQ-021 Wrap-around: with ptr==NREQ-1, index 0 is searched first.
REQ-022 gnt SHALL never have more than one bit set.

Reset
REQ-023 When reset==0 at a rising edge, the block SHALL reset to:
- state=IDLE, gnt=0, busy=0, q=0, qb=all ones, cnt=0;
- ptr=NREQ-1, so requester 0 has first priority.
REQ-024 Reset SHALL take priority over every transition, including mid-HOLD; the grant drops on that edge.

Configuration
REQ-025 Macro REG_SHARE_LOCK_EN SHALL control the lock feature.
- Defined: a 1-bit input lock is added. In HOLD with cnt==0, req[ptr]==1 and lock==1, the grant is held and the FSM stays in HOLD. Early release per REQ-018 still applies.
- Undefined: there is no lock port, and REQ-017 applies unconditionally.

Structure
REQ-026 Package reg_share_pkg SHALL hold:
- the state enum (IDLE, HOLD);
- default constants NREQ_DEF=4, WIDTH_DEF=8, HOLD_DEF=2;
- the counter width constant CNT_W=4.
REQ-027 Sub-module rr_pick SHALL implement the combinational rotate-priority search: inputs req and ptr; outputs winner index and valid.

Verification (NREQ=4, WIDTH=8, HOLD=2)
REQ-028 Reset, then req=0001, wr_data[0]=8'hA5:
- gnt=0001 for 2 cycles, q=8'hA5, qb=8'h5A, busy high for 2 cycles;
- then gnt=0000.
REQ-029 req=1111 held constant: grants SHALL follow the order 0001, 0010, 0100, 1000, 0001, each 2 cycles long, with a 1-cycle gap between grants.
REQ-030 Grant to requester 2; drop req[2] after 1 cycle:
- gnt=0000 on the next edge, busy=0, q retained;
- next arbitration starts the search from index 3.
REQ-031 reset asserted while gnt=0100:
- next edge: gnt=0000, q=8'h00, qb=8'hFF;
- with req=0100 and reset released, requester 2 is granted.
REQ-032 With REG_SHARE_LOCK_EN defined, req=0001 and lock=1 held for 5 cycles: gnt=0001 is held; it drops 1 edge after lock falls.

Source files
------------

// File: rtl/reg_share_pkg.sv
// Shared types and default constants for the register-sharing arbiter.
package reg_share_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StHold
  } state_e;

  localparam int unsigned NREQ_DEF  = 4;
  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned HOLD_DEF  = 2;
  localparam int unsigned CNT_W     = 4;

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority search: first asserted request strictly after ptr, wrapping modulo NREQ.
module rr_pick
  import reg_share_pkg::*;
#(
  parameter  int unsigned NREQ = NREQ_DEF,
  localparam int unsigned IdxW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IdxW-1:0] ptr,
  output logic [IdxW-1:0] winner,
  output logic            valid
);

  logic [IdxW-1:0] idx;

  // Scan farthest offset first so the nearest hit after ptr overwrites the rest.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = IdxW'((32'(ptr) + 32'(k)) % NREQ);
      if (req[idx]) begin
        winner = idx;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter granting one requester timed write access to a shared register.
// Define REG_SHARE_LOCK_EN to add a lock input that extends a grant past its hold time.
module reg_share_arbiter
  import reg_share_pkg::*;
#(
  parameter int unsigned NREQ  = NREQ_DEF,
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned HOLD  = HOLD_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] wr_data,
`ifdef REG_SHARE_LOCK_EN
  input  logic                  lock,
`endif
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      q,
  output logic [WIDTH-1:0]      qb,
  output logic                  busy
);

  localparam int unsigned IdxW = $clog2(NREQ);

  state_e           state_q;
  logic [IdxW-1:0]  ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [IdxW-1:0]  winner;
  logic             valid;
  logic [WIDTH-1:0] win_data;
  logic             lock_hold;

`ifdef REG_SHARE_LOCK_EN
  assign lock_hold = lock;
`else
  assign lock_hold = 1'b0;
`endif

  rr_pick #(
    .NREQ(NREQ)
  ) u_rr_pick (
    .req   (req),
    .ptr   (ptr_q),
    .winner(winner),
    .valid (valid)
  );

  always_comb begin
    win_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner == IdxW'(i)) begin
        win_data = wr_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Arbitration only happens from idle, which guarantees a gap cycle between grants.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      gnt     <= '0;
      busy    <= 1'b0;
      q       <= '0;
      cnt_q   <= '0;
      ptr_q   <= IdxW'(NREQ - 1);
    end else begin
      case (state_q)
        StIdle: begin
          if (valid) begin
            gnt     <= NREQ'(1) << winner;
            q       <= win_data;
            ptr_q   <= winner;
            cnt_q   <= CNT_W'(HOLD - 1);
            busy    <= 1'b1;
            state_q <= StHold;
          end
        end
        StHold: begin
          if (!req[ptr_q]) begin
            gnt     <= '0;
            busy    <= 1'b0;
            state_q <= StIdle;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (!lock_hold) begin
            gnt     <= '0;
            busy    <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: begin
          gnt     <= '0;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign qb = ~q;

  gnt_onehot_a : assert property (@(posedge clk) $onehot0(gnt));
  busy_gnt_a   : assert property (@(posedge clk) busy == (gnt != '0));

endmodule
